// File: rtl/game_pkg.sv
// Shared types and constants for the board-game animation path.
package game_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      MOVE     = 3'd1,
      DONE     = 3'd2,
      POST     = 3'd3,
      EV_MOVE  = 3'd4,
      EV_DWELL = 3'd5,
      WIN      = 3'd6
   } anim_state_t;

   localparam logic [3:0] EV_NONE = 4'd0;
   localparam logic [3:0] EV_BACK = 4'd3;
   localparam logic [3:0] EV_WIN  = 4'd10;

   localparam int BOARD_MAX = 10;

   function automatic logic [3:0] clamp_pos(input logic [3:0] pos, input logic [3:0] max_pos);
      return (pos > max_pos) ? max_pos : pos;
   endfunction

endpackage

// File: rtl/frame_divider.sv
// Counts frame_tick pulses; done fires on the tick that completes TERMINAL ticks.
module frame_divider #(
   parameter int TERMINAL = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic clear,
   output logic done
);

   logic [7:0] count;

   assign done = tick && !clear && (count == 8'(TERMINAL - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= 8'd0;
      end else if (clear || done) begin
         count <= 8'd0;
      end else if (tick) begin
         count <= count + 8'd1;
      end
   end

endmodule

// File: rtl/move_anim_scheduler.sv
// Steps the active player's displayed token toward the game position, then plays events.
// Optional WIN_BLINK_EN: blink the winner's token while in WIN.
module move_anim_scheduler
   import game_pkg::*;
#(
   parameter int STEP_FRAMES = 15,
   parameter int EVENT_DWELL = 30,
   parameter int MAX_POS     = BOARD_MAX
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       pos_valid,
   input  logic       turn,
   input  logic [3:0] p1_pos,
   input  logic [3:0] p2_pos,
   input  logic [3:0] event_flag,
   output logic       turn_done,
   output logic [3:0] disp_p1,
   output logic [3:0] disp_p2,
   output logic [1:0] disp_vis,
   output logic       anim_busy,
   output logic       anim_player,
   output logic [2:0] dbg_state
);

   localparam logic [3:0] MAX_POS_C = 4'(MAX_POS);

   anim_state_t state, state_next;
   logic        pos_valid_prev;
   logic [3:0]  target, target_next;
   logic        player_next;
   logic [3:0]  disp_p1_next, disp_p2_next;
   logic        turn_done_next;
   logic        pv_edge;
   logic [3:0]  live_target, turn_target, turn_disp, cur_disp, step_pos;
   logic        disp_wr;
   logic [3:0]  disp_wr_val;
   logic        step_clear, step_done, dwell_clear, dwell_done;

   assign pv_edge     = pos_valid & ~pos_valid_prev;
   assign live_target = clamp_pos(anim_player ? p2_pos : p1_pos, MAX_POS_C);
   assign turn_target = clamp_pos(turn ? p2_pos : p1_pos, MAX_POS_C);
   assign turn_disp   = turn ? disp_p2 : disp_p1;
   assign cur_disp    = anim_player ? disp_p2 : disp_p1;
   // Only evaluated while cur_disp != target, so it never wraps past 0 or MAX_POS.
   assign step_pos    = (cur_disp < target) ? cur_disp + 4'd1 : cur_disp - 4'd1;

   assign step_clear  = !((state == MOVE) || (state == EV_MOVE));
   assign dwell_clear = (state != EV_DWELL);

   frame_divider #(.TERMINAL(STEP_FRAMES)) u_step (
      .clk   (clk),
      .reset (reset),
      .tick  (frame_tick),
      .clear (step_clear),
      .done  (step_done)
   );

   frame_divider #(.TERMINAL(EVENT_DWELL)) u_dwell (
      .clk   (clk),
      .reset (reset),
      .tick  (frame_tick),
      .clear (dwell_clear),
      .done  (dwell_done)
   );

   always_comb begin
      state_next     = state;
      target_next    = target;
      player_next    = anim_player;
      turn_done_next = 1'b0;
      disp_wr        = 1'b0;
      disp_wr_val    = cur_disp;
      case (state)
         IDLE: begin
            if (pv_edge) begin
               player_next = turn;
               target_next = turn_target;
               state_next  = (turn_target == turn_disp) ? DONE : MOVE;
            end
         end
         MOVE: begin
            // Follow late corrections from the game side.
            target_next = live_target;
            if (cur_disp == target) begin
               state_next = DONE;
            end else if (step_done) begin
               disp_wr     = 1'b1;
               disp_wr_val = step_pos;
            end
         end
         DONE: begin
            turn_done_next = 1'b1;
            state_next     = POST;
         end
         POST: begin
            if (!pos_valid) begin
               target_next = live_target;
               if (event_flag == EV_WIN) begin
                  state_next = WIN;
               end else if (event_flag != EV_NONE) begin
                  state_next = (live_target != cur_disp) ? EV_MOVE : EV_DWELL;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         EV_MOVE: begin
            if (cur_disp == target) begin
               state_next = EV_DWELL;
            end else if (target < cur_disp) begin
               if (frame_tick) begin
                  disp_wr     = 1'b1;
                  disp_wr_val = target;
               end
            end else if (step_done) begin
               disp_wr     = 1'b1;
               disp_wr_val = step_pos;
            end
         end
         EV_DWELL: begin
            if (dwell_done) begin
               turn_done_next = 1'b1;
               state_next     = IDLE;
            end
         end
         WIN: begin
            state_next = WIN;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      disp_p1_next = disp_p1;
      disp_p2_next = disp_p2;
      if (disp_wr && !anim_player) disp_p1_next = disp_wr_val;
      if (disp_wr && anim_player)  disp_p2_next = disp_wr_val;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         pos_valid_prev <= 1'b0;
         target         <= 4'd0;
         anim_player    <= 1'b0;
         disp_p1        <= 4'd0;
         disp_p2        <= 4'd0;
         turn_done      <= 1'b0;
      end else begin
         state          <= state_next;
         pos_valid_prev <= pos_valid;
         target         <= target_next;
         anim_player    <= player_next;
         disp_p1        <= disp_p1_next;
         disp_p2        <= disp_p2_next;
         turn_done      <= turn_done_next;
      end
   end

   assign anim_busy = (state == MOVE) || (state == EV_MOVE) || (state == EV_DWELL);
   assign dbg_state = state;

`ifdef WIN_BLINK_EN
   logic [3:0] blink_cnt;
   logic [1:0] vis_reg;
   logic       winner;

   // P1 takes precedence when both (or neither) sit on the last square.
   assign winner = (disp_p1 != MAX_POS_C) && (disp_p2 == MAX_POS_C);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_cnt <= 4'd0;
         vis_reg   <= 2'b11;
      end else if (state == WIN) begin
         if (frame_tick) begin
            blink_cnt <= blink_cnt + 4'd1;
            if (blink_cnt == 4'd15) vis_reg[winner] <= ~vis_reg[winner];
         end
      end else begin
         blink_cnt <= 4'd0;
         vis_reg   <= 2'b11;
      end
   end

   assign disp_vis = vis_reg;
`else
   assign disp_vis = 2'b11;
`endif

endmodule

// File: doc/move_anim_scheduler.md
Name: move_anim_scheduler

Overview:
- Sequences token animation for the two-player board UI. Bridges the game FSM's position updates to the renderer.
- On each position update it steps the active player's displayed token one square per STEP_FRAMES frames toward the game position, then pulses turn_done.
- It then samples event_flag. Event moves (e.g. back-to-start) and dwells are animated, and turn_done is pulsed a second time.
- Sits between the game logic controller (pos_valid, p*_pos, turn, event_flag) and the board renderer (disp_p1/disp_p2). Single clock domain.

Parameters:
- STEP_FRAMES, 15, frame_tick pulses per one-square step (range 1..255).
- EVENT_DWELL, 30, frame_tick pulses held for a non-moving event (range 1..255).
- MAX_POS, 10, last board square; targets above it are clamped to it.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- frame_tick  in  1  one-cycle pulse per video frame
- pos_valid  in  1  level; high while the game FSM waits for the move animation
- turn  in  1  active player: 0 = P1, 1 = P2
- p1_pos  in  4  P1 game position
- p2_pos  in  4  P2 game position
- event_flag  in  4  event code: 0 = none, 2/3/4/6/8 = square events, 10 = win
- turn_done  out  1  one-cycle completion pulse
- disp_p1  out  4  P1 displayed square
- disp_p2  out  4  P2 displayed square
- disp_vis  out  2  token visibility [1] = P2, [0] = P1
- anim_busy  out  1  high in MOVE, EV_MOVE, EV_DWELL
- anim_player  out  1  player latched at move start
- dbg_state  out  3  state encoding

Behaviour:
Reset values (asynchronous):
- state = IDLE; disp_p1 = disp_p2 = 0; disp_vis = 2'b11.
- turn_done = 0; anim_busy = 0; anim_player = 0.
- Frame counter = 0; target = 0.

States: IDLE, MOVE, DONE, POST, EV_MOVE, EV_DWELL, WIN.

- IDLE:
  - Rising edge of pos_valid (registered previous value) latches anim_player = turn.
  - Also latches target = min(selected p*_pos, MAX_POS) and clears the frame counter.
  - If target == displayed position, go to DONE; otherwise go to MOVE.
- MOVE:
  - Count frame_tick. When the count reaches STEP_FRAMES-1 with a tick present, move the displayed position ±1 toward target and clear the counter.
  - On the cycle the displayed position equals target, go to DONE.
  - First step lands STEP_FRAMES ticks after entry.
  - The target is re-sampled every cycle from the live p*_pos of anim_player, so a late game-side correction is followed.
- DONE:
  - Assert turn_done for exactly one cycle, then go to POST.
- POST:
  - Wait until pos_valid == 0. In that same cycle sample event_flag and re-latch target from the live p*_pos.
  - 10 → WIN.
  - Nonzero, with target ≠ displayed position → EV_MOVE.
  - Nonzero, with target == displayed position → EV_DWELL.
  - 0 → IDLE; no second turn_done.
- EV_MOVE:
  - Downward moves (target < displayed position) jump directly to target on the first frame_tick.
  - Upward moves step exactly as in MOVE.
  - On arrival go to EV_DWELL.
- EV_DWELL:
  - Count EVENT_DWELL frame_ticks, then pulse turn_done for one cycle and go to IDLE.
- WIN:
  - Terminal until reset. disp_* hold their values; anim_busy = 0.

Rules:
- Positions are 4-bit unsigned. Steps never go below 0 or above MAX_POS.
- A pos_valid rising edge outside IDLE is ignored; no queuing.
- turn_done is never asserted in two consecutive cycles.
- frame_tick and the pos_valid edge arriving in the same cycle: IDLE takes the edge; the tick is not counted.
- Reset mid-animation: immediate return to reset values.

Optional Feature:
- Macro: WIN_BLINK_EN.
- Defined: in WIN, the winner's disp_vis bit toggles every 16 frame_ticks, and the loser's bit stays 1. The winner is the player with displayed position == MAX_POS; P1 wins a tie. A 4-bit blink counter is added.
- Undefined: disp_vis is tied to 2'b11 and no blink counter exists.

Decomposition:
- Shared package game_pkg:
  - anim_state_t enum.
  - Event code constants: EV_NONE = 0, EV_BACK = 3, EV_WIN = 10.
  - BOARD_MAX = 10 (default for MAX_POS).
- One sub-module: frame_divider. It holds the frame_tick counter with terminal-count parameter, clear input and done pulse output, and is reused for the step and dwell timing.

Test Plan:
- Move: reset; turn = 0; p1_pos = 3; pos_valid rises; STEP_FRAMES = 2 → disp_p1 goes 1, 2, 3 on ticks 2, 4, 6. One turn_done pulse follows, and disp_p2 stays 0.
- Event back-to-start: after a P2 move to 3, drop pos_valid with event_flag = 3 and p2_pos = 0. disp_p2 must jump to 0 on the next tick, then after EVENT_DWELL ticks a second turn_done pulse.
- No event: drop pos_valid with event_flag = 0 → return to IDLE; exactly one turn_done total.
- Win: p1_pos = 12 with pos_valid → disp_p1 is clamped to 10. Then event_flag = 10 → WIN; later pos_valid edges are ignored. With WIN_BLINK_EN, disp_vis[0] toggles every 16 ticks.
- Zero move: pos_valid rises with p1_pos == disp_p1 → turn_done exactly 2 cycles after the edge is registered.
- Reset at mid-MOVE step 2 → all outputs return to reset values; the next pos_valid edge restarts cleanly.
